// File: rtl/block_check_scheduler_pkg.sv
// Shared types and constants for the begin/end checker scheduler.
// State encoding is fixed so that the values stay stable for debug probes.
package block_check_scheduler_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_CAPT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    PLAY = ST_PLAY,
    CAPT = ST_CAPT
  } state_t;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Round-robin pick between two requesters; on a tie the one not served last wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
    if (&valid) return ~last_grant;
    return valid[1];
  endfunction

endpackage

// File: rtl/block_check_scheduler_sentence_buffer.sv
// Sentence storage with write-length and replay-pointer counters.
// Write is synchronous at len; read is combinational at rd.
module sentence_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       len_clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_clr,
  input  logic       rd_inc,
  output logic [7:0] rd_data,
  output logic       last_rd,
  output logic       wr_last_slot
);

  localparam logic [AW:0] LAST_SLOT = (AW + 1)'(DEPTH - 1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] len;
  logic [AW-1:0] rd;

  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
    end else if (len_clr) begin
      len <= '0;
    end else if (wr_en) begin
      len <= len + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
    end else if (rd_clr) begin
      rd <= '0;
    end else if (rd_inc) begin
      rd <= rd + 1'b1;
    end
  end

  assign rd_data      = mem[rd];
  assign last_rd      = ({1'b0, rd} == (len - 1'b1));
  assign wr_last_slot = (len == LAST_SLOT);

endmodule

// File: rtl/block_check_scheduler.sv
// Time-shares one begin/end checker between two sentence requesters:
// buffer a whole sentence, replay it gap-free into a freshly reset checker, return the result.
//
// state | meaning
// IDLE  | arbitrate between requesters, checker held in reset
// LOAD  | accept owner's characters into the buffer
// PLAY  | replay buffer into checker, one character per cycle
// CAPT  | latch checker result and overflow flag for the owner
module block_check_scheduler
  import block_check_scheduler_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_char0,
  input  logic [7:0] req_char1,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic       chk_reset,
  output logic [7:0] chk_in,
  input  logic       chk_result,
  output logic [1:0] done,
  output logic [1:0] res,
  output logic [1:0] err,
  output logic       busy
);

  state_t     state, state_nxt;
  logic       owner;
  logic       last_grant;
  logic       ovf;

  logic       grant_fire;
  logic       grant_sel;
  logic       set_ovf;
  logic       capture;
  logic       len_clr;
  logic       rd_clr;
  logic       rd_inc;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       last_rd;
  logic       wr_last_slot;
  logic       own_valid;
  logic       own_last;

  assign own_valid = req_valid[owner];
  assign own_last  = req_last[owner];
  assign wr_data   = owner ? req_char1 : req_char0;
  assign grant_sel = rr_pick(req_valid, last_grant);

  sentence_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk          (clk),
    .reset        (reset),
    .len_clr      (len_clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_clr       (rd_clr),
    .rd_inc       (rd_inc),
    .rd_data      (rd_data),
    .last_rd      (last_rd),
    .wr_last_slot (wr_last_slot)
  );

  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    chk_reset  = 1'b1;
    chk_in     = SPACE_CHAR;
    grant_fire = 1'b0;
    set_ovf    = 1'b0;
    capture    = 1'b0;
    len_clr    = 1'b0;
    rd_clr     = 1'b0;
    rd_inc     = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        rd_clr = 1'b1;
        if (|req_valid) begin
          grant_fire = 1'b1;
          len_clr    = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        req_ready = owner ? 2'b10 : 2'b01;
        if (own_valid) begin
          wr_en = 1'b1;
          // A full buffer closes the sentence even without last.
          if (own_last || wr_last_slot) state_nxt = PLAY;
          if (!own_last && wr_last_slot) set_ovf = 1'b1;
        end
      end
      PLAY: begin
        chk_reset = 1'b0;
        chk_in    = rd_data;
        rd_inc    = 1'b1;
        if (last_rd) state_nxt = CAPT;
      end
      CAPT: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ovf        <= 1'b0;
      done       <= 2'b00;
      res        <= 2'b00;
      err        <= 2'b00;
    end else begin
      state <= state_nxt;
      done  <= 2'b00;
      if (grant_fire) owner <= grant_sel;
      if (set_ovf) ovf <= 1'b1;
      if (capture) begin
        res[owner]  <= chk_result;
        err[owner]  <= ovf;
        done[owner] <= 1'b1;
        ovf         <= 1'b0;
        last_grant  <= owner;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_block_check_scheduler.sv
// Directed bench for block_check_scheduler with a behavioural begin/end checker model
// attached to each of two instances (DEPTH 64 and DEPTH 8) sharing one stimulus bus.
module tb_block_check_scheduler;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_char0 = 8'h20;
  logic [7:0] req_char1 = 8'h20;
  logic [1:0] req_last = 2'b00;

  logic [1:0] ready_a, done_a, res_a, err_a;
  logic       chk_reset_a, chk_result_a, busy_a;
  logic [7:0] chk_in_a;
  logic [1:0] ready_b, done_b, res_b, err_b;
  logic       chk_reset_b, chk_result_b, busy_b;
  logic [7:0] chk_in_b;

  always #(P/2) clk = ~clk;

  block_check_scheduler #(.DEPTH(64)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_char0(req_char0),
    .req_char1(req_char1), .req_last(req_last), .req_ready(ready_a),
    .chk_reset(chk_reset_a), .chk_in(chk_in_a), .chk_result(chk_result_a),
    .done(done_a), .res(res_a), .err(err_a), .busy(busy_a));

  block_check_scheduler #(.DEPTH(8)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_char0(req_char0),
    .req_char1(req_char1), .req_last(req_last), .req_ready(ready_b),
    .chk_reset(chk_reset_b), .chk_in(chk_in_b), .chk_result(chk_result_b),
    .done(done_b), .res(res_b), .err(err_b), .busy(busy_b));

  // Checker model: "begin" opens, "end" closes; result is 1 when balanced with no underflow.
  function automatic int word_delta(input logic [39:0] w, input int wl);
    if (wl == 5 && w == "begin") return 1;
    if (wl == 3 && w[23:0] == "end") return -1;
    return 0;
  endfunction

  function automatic logic model_result(input int d, input logic bad, input logic [39:0] w, input int wl);
    int t;
    t = d + word_delta(w, wl);
    return !bad && (t == 0);
  endfunction

  int          ma_depth = 0, mb_depth = 0, ma_wlen = 0, mb_wlen = 0;
  logic        ma_bad = 1'b0, mb_bad = 1'b0;
  logic [39:0] ma_word = '0, mb_word = '0;

  always @(posedge clk) begin
    if (chk_reset_a) begin
      ma_depth <= 0; ma_bad <= 1'b0; ma_word <= '0; ma_wlen <= 0;
    end else if (chk_in_a == 8'h20) begin
      ma_depth <= ma_depth + word_delta(ma_word, ma_wlen);
      if (ma_depth + word_delta(ma_word, ma_wlen) < 0) ma_bad <= 1'b1;
      ma_word <= '0; ma_wlen <= 0;
    end else begin
      ma_word <= {ma_word[31:0], chk_in_a};
      if (ma_wlen < 8) ma_wlen <= ma_wlen + 1;
    end
  end

  always @(posedge clk) begin
    if (chk_reset_b) begin
      mb_depth <= 0; mb_bad <= 1'b0; mb_word <= '0; mb_wlen <= 0;
    end else if (chk_in_b == 8'h20) begin
      mb_depth <= mb_depth + word_delta(mb_word, mb_wlen);
      if (mb_depth + word_delta(mb_word, mb_wlen) < 0) mb_bad <= 1'b1;
      mb_word <= '0; mb_wlen <= 0;
    end else begin
      mb_word <= {mb_word[31:0], chk_in_b};
      if (mb_wlen < 8) mb_wlen <= mb_wlen + 1;
    end
  end

  assign chk_result_a = model_result(ma_depth, ma_bad, ma_word, ma_wlen);
  assign chk_result_b = model_result(mb_depth, mb_bad, mb_word, mb_wlen);

  typedef struct {
    int     who;
    logic   r;
    logic   e;
    longint t;
  } drec_t;

  drec_t dq_a[$];
  drec_t dq_b[$];
  int    both_rdy = 0;
  int    both_done = 0;
  int    play_cnt = 0;
  int    play_runs = 0;
  logic  prev_chk_a = 1'b1;

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (done_a[n]) dq_a.push_back('{who: n, r: res_a[n], e: err_a[n], t: $time});
      if (done_b[n]) dq_b.push_back('{who: n, r: res_b[n], e: err_b[n], t: $time});
    end
    if (ready_a == 2'b11 || ready_b == 2'b11) both_rdy <= both_rdy + 1;
    if (done_a == 2'b11 || done_b == 2'b11) both_done <= both_done + 1;
    if (!chk_reset_a) play_cnt <= play_cnt + 1;
    if (prev_chk_a && !chk_reset_a) play_runs <= play_runs + 1;
    prev_chk_a <= chk_reset_a;
  end

  int     checks = 0;
  int     failures = 0;
  string  qs[2][$];
  int     gap_at[2] = '{-1, -1};
  int     gap_len[2] = '{0, 0};
  bit     sel8 = 1'b0;
  longint t_acc[2] = '{0, 0};

  initial begin
    #(P * 20000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    req_last = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams queued sentences for both requesters; last set on each sentence's final char.
  task automatic drive(input int budget);
    int         idx[2];
    int         gleft[2];
    int         cyc;
    logic [1:0] v, l, rdy;
    logic [7:0] c[2];
    string      s;
    idx = '{0, 0};
    gleft = gap_len;
    cyc = 0;
    while ((qs[0].size() != 0 || qs[1].size() != 0) && cyc < budget) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        v[n] = 1'b0; l[n] = 1'b0; c[n] = 8'h20;
        if (qs[n].size() != 0) begin
          if (idx[n] == gap_at[n] && gleft[n] > 0) begin
            gleft[n]--;
          end else begin
            s = qs[n][0];
            v[n] = 1'b1;
            c[n] = s[idx[n]];
            l[n] = (idx[n] == s.len() - 1);
          end
        end
      end
      req_valid = v; req_char0 = c[0]; req_char1 = c[1]; req_last = l;
      rdy = sel8 ? ready_b : ready_a;
      @(posedge clk);
      for (int n = 0; n < 2; n++) begin
        if (v[n] && rdy[n]) begin
          if (l[n]) begin
            void'(qs[n].pop_front());
            idx[n] = 0;
            t_acc[n] = $time;
          end else begin
            idx[n]++;
          end
        end
      end
      cyc++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    req_last = 2'b00;
    checks++;
    if (qs[0].size() != 0 || qs[1].size() != 0) begin
      failures++;
      $display("FAIL drive_timeout: pending sentences %0d/%0d, required 0/0", qs[0].size(), qs[1].size());
      qs[0].delete(); qs[1].delete();
    end
  endtask

  task automatic wait_dones(input bit on_b, input int target, input int budget);
    int cyc;
    cyc = 0;
    while ((on_b ? dq_b.size() : dq_a.size()) < target && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if ((on_b ? dq_b.size() : dq_a.size()) < target) begin
      failures++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", on_b ? dq_b.size() : dq_a.size(), target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_a !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b required 00", ready_a); end
    checks++; if (done_a !== 2'b00) begin failures++; $display("FAIL rst_done: got %b required 00", done_a); end
    checks++; if (res_a !== 2'b00 || err_a !== 2'b00) begin failures++; $display("FAIL rst_res_err: got %b/%b required 00/00", res_a, err_a); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b/%b required 0/0", busy_a, busy_b); end
    checks++; if (chk_reset_a !== 1'b1) begin failures++; $display("FAIL rst_chk_reset: got %b required 1", chk_reset_a); end
    checks++; if (chk_in_a !== 8'h20) begin failures++; $display("FAIL rst_chk_in: got %h required 20", chk_in_a); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int base;
    do_reset();
    base = dq_a.size();
    qs[0].push_back("begin end");
    drive(200);
    wait_dones(1'b0, base + 1, 50);
    if (dq_a.size() > base) begin
      checks++; if (dq_a[base].who != 0) begin failures++; $display("FAIL single_who: got %0d required 0", dq_a[base].who); end
      checks++; if (dq_a[base].r !== 1'b1 || dq_a[base].e !== 1'b0) begin failures++; $display("FAIL single_res: got res=%b err=%b required res=1 err=0", dq_a[base].r, dq_a[base].e); end
      checks++; if (dq_a[base].t - t_acc[0] != 10 * P + P / 2) begin failures++; $display("FAIL single_latency: got %0d ns required %0d ns", dq_a[base].t - t_acc[0], 10 * P + P / 2); end
    end
    @(negedge clk);
    checks++; if (res_a[0] !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL single_hold: got res0=%b busy=%b required 1/0", res_a[0], busy_a); end
  endtask

  task automatic test_fresh_checker();
    int base;
    do_reset();
    base = dq_a.size();
    qs[1].push_back("begin");
    qs[1].push_back("end");
    drive(300);
    wait_dones(1'b0, base + 2, 50);
    if (dq_a.size() >= base + 2) begin
      checks++; if (dq_a[base].who != 1 || dq_a[base].r !== 1'b0) begin failures++; $display("FAIL fresh_begin: got who=%0d res=%b required who=1 res=0", dq_a[base].who, dq_a[base].r); end
      checks++; if (dq_a[base+1].who != 1 || dq_a[base+1].r !== 1'b0) begin failures++; $display("FAIL fresh_end: got who=%0d res=%b required who=1 res=0", dq_a[base+1].who, dq_a[base+1].r); end
    end
  endtask

  task automatic test_back_to_back();
    int base, rdy0;
    int exp_who[3] = '{0, 1, 0};
    logic exp_r[3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    base = dq_a.size();
    rdy0 = both_rdy;
    qs[0].push_back("begin end");
    qs[0].push_back("end");
    qs[1].push_back("x");
    drive(400);
    wait_dones(1'b0, base + 3, 50);
    if (dq_a.size() >= base + 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dq_a[base+k].who != exp_who[k] || dq_a[base+k].r !== exp_r[k]) begin
          failures++;
          $display("FAIL rr_order[%0d]: got who=%0d res=%b required who=%0d res=%b", k, dq_a[base+k].who, dq_a[base+k].r, exp_who[k], exp_r[k]);
        end
      end
    end
    checks++; if (both_rdy != rdy0) begin failures++; $display("FAIL rr_ready_exclusive: got %0d dual-ready cycles required 0", both_rdy - rdy0); end
    checks++; if (both_done != 0) begin failures++; $display("FAIL rr_done_exclusive: got %0d dual-done cycles required 0", both_done); end
  endtask

  task automatic test_gap();
    int base, pc0, pr0;
    do_reset();
    base = dq_a.size();
    pc0 = play_cnt;
    pr0 = play_runs;
    gap_at[0] = 3;
    gap_len[0] = 5;
    qs[0].push_back("begin end");
    drive(200);
    gap_at[0] = -1;
    gap_len[0] = 0;
    wait_dones(1'b0, base + 1, 50);
    if (dq_a.size() > base) begin
      checks++; if (dq_a[base].r !== 1'b1 || dq_a[base].e !== 1'b0) begin failures++; $display("FAIL gap_res: got res=%b err=%b required res=1 err=0", dq_a[base].r, dq_a[base].e); end
    end
    checks++; if (play_cnt - pc0 != 9) begin failures++; $display("FAIL gap_play_len: got %0d cycles required 9", play_cnt - pc0); end
    checks++; if (play_runs - pr0 != 1) begin failures++; $display("FAIL gap_play_runs: got %0d runs required 1", play_runs - pr0); end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    sel8 = 1'b1;
    base = dq_b.size();
    qs[0].push_back("begin enda");
    drive(300);
    wait_dones(1'b1, base + 2, 50);
    if (dq_b.size() >= base + 2) begin
      checks++; if (dq_b[base].r !== 1'b0 || dq_b[base].e !== 1'b1) begin failures++; $display("FAIL ovf_first: got res=%b err=%b required res=0 err=1", dq_b[base].r, dq_b[base].e); end
      checks++; if (dq_b[base+1].r !== 1'b1 || dq_b[base+1].e !== 1'b0) begin failures++; $display("FAIL ovf_tail: got res=%b err=%b required res=1 err=0", dq_b[base+1].r, dq_b[base+1].e); end
    end
    @(negedge clk);
    checks++; if (err_b[0] !== 1'b0) begin failures++; $display("FAIL ovf_err_hold: got %b required 0", err_b[0]); end
    sel8 = 1'b0;
  endtask

  task automatic test_reset_in_play();
    int base;
    do_reset();
    base = dq_a.size();
    qs[0].push_back("begin end");
    drive(200);
    wait_dones(1'b0, base + 1, 50);
    @(negedge clk);
    checks++; if (res_a[0] !== 1'b1) begin failures++; $display("FAIL rip_pre_res: got %b required 1", res_a[0]); end
    qs[0].push_back("begin end");
    drive(200);
    repeat (2) @(negedge clk);
    checks++; if (chk_reset_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL rip_in_play: got chk_reset=%b busy=%b required 0/1", chk_reset_a, busy_a); end
    base = dq_a.size();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy_a !== 1'b0 || chk_reset_a !== 1'b1) begin failures++; $display("FAIL rip_idle: got busy=%b chk_reset=%b required 0/1", busy_a, chk_reset_a); end
    checks++; if (res_a !== 2'b00 || err_a !== 2'b00) begin failures++; $display("FAIL rip_res_clear: got res=%b err=%b required 00/00", res_a, err_a); end
    repeat (20) @(posedge clk);
    checks++; if (dq_a.size() != base) begin failures++; $display("FAIL rip_no_done: got %0d done pulses required 0", dq_a.size() - base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fresh_checker();
    test_back_to_back();
    test_gap();
    test_overflow();
    test_reset_in_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_check_scheduler.md
# block_check_scheduler

Shares one keyword-nesting checker (the begin/end sentence checker: 8-bit character in, combinational `result` out, synchronous active-high reset) between two requesters. Each requester streams a sentence over a valid/ready handshake. The scheduler buffers the whole sentence, clears the checker, and replays the sentence into it one character per cycle with no gaps. It then captures `result` and returns it to the owning requester. It sits between the character sources and the single checker instance.

## Interface

Parameters:
- `DEPTH`, default 64: sentence buffer capacity in characters; must be a power of 2, ≥ 2.
- `AW`, default `$clog2(DEPTH)`: buffer address width; the length counter is `AW+1` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — synchronous, active-high; clears all state.
- `req_valid[1:0]`  in  2  — requester *n* presents a character.
- `req_char0`, `req_char1`  in  8 each  — ASCII character from requester 0 / 1.
- `req_last[1:0]`  in  2  — the presented character ends the sentence.
- `req_ready[1:0]`  out  2  — a character is accepted when `req_valid[n] & req_ready[n]` at the edge.
- `chk_reset`  out  1  — drives the checker's `reset`.
- `chk_in`  out  8  — drives the checker's `in`.
- `chk_result`  in  1  — checker's combinational `result`.
- `done[1:0]`  out  2  — one-cycle pulse: result available for requester *n*.
- `res[1:0]`  out  2  — per-requester result; holds until that requester's next `done`.
- `err[1:0]`  out  2  — per-requester overflow flag; updated together with `res`.
- `busy`  out  1  — high in every state except IDLE.

## Operation

States: IDLE, LOAD, PLAY, CAPT.
- **IDLE**
  - Round-robin grant: if both `req_valid` bits are high, grant the requester not granted last. Otherwise grant whichever is high.
  - On a grant: store `owner`, clear `len`, go to LOAD.
- **LOAD**
  - `req_ready[owner]=1`; the other `req_ready` bit is 0.
  - Each accepted character is written to `buf[len]`, then `len++`.
  - An accepted character with `req_last=1` moves the block to PLAY.
  - Overflow: when the accepted character fills slot `DEPTH-1` without `last`, it is treated as last. Set `ovf=1` and go to PLAY.
  - A requester that keeps sending after an overflow is treated as starting a new sentence.
  - `req_valid` may drop mid-sentence. The block waits in LOAD; the checker is held in reset, so gaps are harmless.
- **PLAY**
  - `chk_reset=0`; `chk_in=buf[rd]` with `rd` running 0..`len-1`, exactly one character per cycle.
  - After `rd==len-1`, go to CAPT.
- **CAPT**
  - Sample `chk_result` into `res[owner]` and `ovf` into `err[owner]`.
  - Pulse `done[owner]`, clear `ovf`, update last-granted, return to IDLE.
- Outside PLAY: `chk_reset=1` and `chk_in=8'h20`. The checker therefore always starts a sentence from its reset state.
- An overflowed sentence is still checked on its truncated contents; `err` marks it.

## Timing

- Reset values:
  - state IDLE; `len`, `rd`, `ovf` = 0; last-granted = 1 (requester 0 wins the first tie).
  - `req_ready`, `done`, `res`, `err`, `busy` = 0; `chk_reset`=1; `chk_in`=8'h20.
- IDLE→LOAD takes 1 cycle after `req_valid` is seen; `req_ready` rises in the first LOAD cycle.
- Let the last character (length L) be accepted at edge *t*:
  - PLAY covers cycles t+1..t+L.
  - CAPT is cycle t+L+1.
  - `done` and the new `res`/`err` are visible in cycle t+L+2.
- A new grant can be evaluated in the cycle `done` is high, so back-to-back sentences are possible.
- `reset` in any state wins: return to IDLE and drop the sentence. No `done` is issued for it; `res`/`err` are cleared.
- A non-owner's `req_valid` is ignored until IDLE. Its data must be held stable, per the handshake.

## Structure

- Shared package holds:
  - state encoding (2-bit localparams IDLE=0, LOAD=1, PLAY=2, CAPT=3);
  - `SPACE_CHAR = 8'h20`.
- Sub-module `sentence_buffer`:
  - `DEPTH`×8 storage, synchronous write, combinational read at `rd`;
  - owns the `len` and `rd` counters;
  - signals `last_rd`, asserted when `rd==len-1`.
- The top level holds the FSM, arbiter, and result registers. It instantiates the checker externally; the checker is not a child of this block.

## Test plan

- Req0 sends "begin end" (9 chars), req1 idle → `done[0]` in cycle t+11; `res[0]=1`, `err[0]=0`.
- Req1 sends "begin" → `res[1]=0`. Then req1 sends "end" → `res[1]=0` (fresh checker each sentence, no carry-over).
- Both `req_valid` high from reset → req0 served first, then req1, then req0. `req_ready` is never high for both.
- Req0 drops `req_valid` for 5 cycles inside "beg|in end" → `chk_reset` stays 1 during the gap; `res[0]=1`; the PLAY length equals 9 contiguous cycles.
- `DEPTH=8`, send 10 chars without `last` → first 8 checked; `err[0]=1`; the remaining 2 chars form a new sentence with `err=0`.
- `reset` pulsed during PLAY → next cycle IDLE; `busy=0`, `chk_reset=1`, `res=0`, no `done` pulse.
